// File: rtl/pulse_pacer_tx_pkg.sv
// Shared types for the pulse pacer: per-channel FSM states and gap counter width.
package pulse_pacer_tx_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        GAP  = 1'b1
    } pacer_state_e;

    localparam int unsigned GAP_W = 8;

endpackage

// File: rtl/pulse_pacer_chan.sv
// One pacing channel: counts pending input pulses and re-emits them spaced by
// at least P_MIN_GAP+1 cycles, with a sticky overflow flag on saturation.
module pulse_pacer_chan
    import pulse_pacer_tx_pkg::*;
#(
    parameter int unsigned P_MIN_GAP = 8,
    parameter int unsigned P_CNTR_W  = 4
) (
    input  logic clk_ir,
    input  logic rst_il,
    input  logic pulse_ih,
    input  logic clr_ovrflw_ih,
    output logic pulse_oh,
    output logic idle_oh,
    output logic ovrflw_oh
);

    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(P_MIN_GAP - 2);

    pacer_state_e          state_f, state_nx;
    logic [P_CNTR_W-1:0]   pend_f, pend_nx;
    logic [GAP_W-1:0]      gap_f, gap_nx;
    logic                  pulse_f, pulse_nx;
    logic                  ovrflw_f, ovrflw_nx;
    logic                  emit;
    logic                  drop;

    assign emit = (state_f == IDLE) && (pend_f != '0);
    assign drop = pulse_ih && !emit && (pend_f == '1);

    always_ff @(posedge clk_ir or negedge rst_il) begin
        if (!rst_il) begin
            state_f  <= IDLE;
            pend_f   <= '0;
            gap_f    <= '0;
            pulse_f  <= 1'b0;
            ovrflw_f <= 1'b0;
        end else begin
            state_f  <= state_nx;
            pend_f   <= pend_nx;
            gap_f    <= gap_nx;
            pulse_f  <= pulse_nx;
            ovrflw_f <= ovrflw_nx;
        end
    end

    // The countdown holds while the emitted pulse is on the wire, so GAP spans
    // the P_MIN_GAP-1 cycles after the output pulse.
    always_comb begin
        state_nx = state_f;
        gap_nx   = gap_f;
        pulse_nx = 1'b0;
        if (emit) begin
            pulse_nx = 1'b1;
            state_nx = GAP;
            gap_nx   = GAP_LOAD;
        end else if ((state_f == GAP) && !pulse_f) begin
            if (gap_f == '0) begin
                state_nx = IDLE;
            end else begin
                gap_nx = gap_f - 1'b1;
            end
        end
    end

    always_comb begin
        pend_nx = pend_f;
        unique case ({pulse_ih, emit})
            2'b10:   if (pend_f != '1) pend_nx = pend_f + 1'b1;
            2'b01:   pend_nx = pend_f - 1'b1;
            default: pend_nx = pend_f;
        endcase
    end

    always_comb begin
        ovrflw_nx = ovrflw_f;
        if (drop) begin
            ovrflw_nx = 1'b1;
        end else if (clr_ovrflw_ih) begin
            ovrflw_nx = 1'b0;
        end
    end

    assign pulse_oh  = pulse_f;
    assign ovrflw_oh = ovrflw_f;
    assign idle_oh   = (state_f == IDLE) && (pend_f == '0);

endmodule

// File: rtl/pulse_pacer_tx.sv
// Source-domain pacer ahead of the toggle pulse synchronizer: one independent
// pacing channel per pulse bit.
module pulse_pacer_tx #(
    parameter int unsigned P_NO_OF_PULSES = 2,
    parameter int unsigned P_MIN_GAP      = 8,
    parameter int unsigned P_CNTR_W       = 4
) (
    input  logic                      clk_ir,
    input  logic                      rst_il,
    input  logic [P_NO_OF_PULSES-1:0] pulse_ih,
    input  logic [P_NO_OF_PULSES-1:0] clr_ovrflw_ih,
    output logic [P_NO_OF_PULSES-1:0] pulse_oh,
    output logic [P_NO_OF_PULSES-1:0] idle_oh,
    output logic [P_NO_OF_PULSES-1:0] ovrflw_oh
);

    if ((P_MIN_GAP < 2) || (P_MIN_GAP > 255)) begin : g_bad_gap
        $error("pulse_pacer_tx: P_MIN_GAP must lie in 2..255");
    end

    for (genvar i = 0; i < P_NO_OF_PULSES; i++) begin : g_chan
        pulse_pacer_chan #(
            .P_MIN_GAP (P_MIN_GAP),
            .P_CNTR_W  (P_CNTR_W)
        ) u_chan (
            .clk_ir        (clk_ir),
            .rst_il        (rst_il),
            .pulse_ih      (pulse_ih[i]),
            .clr_ovrflw_ih (clr_ovrflw_ih[i]),
            .pulse_oh      (pulse_oh[i]),
            .idle_oh       (idle_oh[i]),
            .ovrflw_oh     (ovrflw_oh[i])
        );
    end

endmodule

// File: tb/tb_pulse_pacer_tx.sv
// Self-checking bench for pulse_pacer_tx against a time-based pacing model.
module tb_pulse_pacer_tx;

    localparam int N    = 2;
    localparam int GAP  = 8;
    localparam int CW   = 4;
    localparam int MAXP = (1 << CW) - 1;

    logic         clk_ir = 1'b0;
    logic         rst_il = 1'b0;
    logic [N-1:0] pulse_ih = '0;
    logic [N-1:0] clr_ovrflw_ih = '0;
    logic [N-1:0] pulse_oh;
    logic [N-1:0] idle_oh;
    logic [N-1:0] ovrflw_oh;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: pending count, earliest cycle an emit may occur, last output, flag.
    int     m_pend[N];
    longint m_next[N];
    bit     m_out[N];
    bit     m_ov[N];
    longint t = 0;

    pulse_pacer_tx #(
        .P_NO_OF_PULSES (N),
        .P_MIN_GAP      (GAP),
        .P_CNTR_W       (CW)
    ) dut (
        .clk_ir        (clk_ir),
        .rst_il        (rst_il),
        .pulse_ih      (pulse_ih),
        .clr_ovrflw_ih (clr_ovrflw_ih),
        .pulse_oh      (pulse_oh),
        .idle_oh       (idle_oh),
        .ovrflw_oh     (ovrflw_oh)
    );

    always #5 clk_ir = ~clk_ir;

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 0;
            m_next[i] = 0;
            m_out[i]  = 1'b0;
            m_ov[i]   = 1'b0;
        end
    endfunction

    function automatic void model_edge(input logic [N-1:0] p, input logic [N-1:0] c);
        for (int i = 0; i < N; i++) begin
            bit emit;
            bit drop;
            emit = (m_pend[i] > 0) && (t >= m_next[i]);
            drop = 1'b0;
            m_out[i] = emit;
            if (emit) m_next[i] = t + 1 + GAP;
            if (p[i] && !emit) begin
                if (m_pend[i] == MAXP) drop = 1'b1;
                else m_pend[i]++;
            end else if (!p[i] && emit) begin
                m_pend[i]--;
            end
            if (drop) m_ov[i] = 1'b1;
            else if (c[i]) m_ov[i] = 1'b0;
        end
        t++;
    endfunction

    function automatic logic [N-1:0] exp_pulse();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = m_out[i];
        return r;
    endfunction

    function automatic logic [N-1:0] exp_idle();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = (m_pend[i] == 0) && (t >= m_next[i]);
        return r;
    endfunction

    function automatic logic [N-1:0] exp_ov();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = m_ov[i];
        return r;
    endfunction

    // Called at posedge+1; drives inputs, advances the model, returns at next posedge+1.
    task automatic step(input logic [N-1:0] p, input logic [N-1:0] c);
        pulse_ih      = p;
        clr_ovrflw_ih = c;
        model_edge(p, c);
        @(posedge clk_ir);
        #1;
    endtask

    task automatic test_reset();
        rst_il   = 1'b0;
        pulse_ih = '1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk_ir);
            #1;
            n_cmp++;
            if ({pulse_oh, idle_oh, ovrflw_oh} !== {{N{1'b0}}, {N{1'b1}}, {N{1'b0}}}) begin
                n_bad++;
                $display("FAIL reset: got p=%b i=%b o=%b, want p=00 i=11 o=00",
                         pulse_oh, idle_oh, ovrflw_oh);
            end
        end
        pulse_ih = '0;
        rst_il   = 1'b1;
        model_reset();
    endtask

    task automatic test_single();
        longint c0, pt, it;
        c0 = t;
        pt = -1;
        it = -1;
        step(2'b01, 2'b00);
        for (int k = 0; k < 20; k++) begin
            n_cmp++;
            if ({pulse_oh, idle_oh, ovrflw_oh} !== {exp_pulse(), exp_idle(), exp_ov()}) begin
                n_bad++;
                $display("FAIL single: cyc %0d got p=%b i=%b o=%b, want p=%b i=%b o=%b",
                         t, pulse_oh, idle_oh, ovrflw_oh, exp_pulse(), exp_idle(), exp_ov());
            end
            if (pulse_oh[0] && pt < 0) pt = t;
            if (pt >= 0 && it < 0 && idle_oh[0]) it = t;
            step(2'b00, 2'b00);
        end
        n_cmp++;
        if (pt != c0 + 2 || it != c0 + 2 + GAP) begin
            n_bad++;
            $display("FAIL single_latency: got pulse@%0d idle@%0d, want pulse@%0d idle@%0d",
                     pt - c0, it - c0, 2, 2 + GAP);
        end
    endtask

    task automatic test_burst();
        longint c0;
        longint times[$];
        int     ch1_seen;
        c0 = t;
        ch1_seen = 0;
        for (int k = 0; k < 60; k++) begin
            step((k < 5) ? 2'b01 : 2'b00, 2'b00);
            n_cmp++;
            if ({pulse_oh, idle_oh, ovrflw_oh} !== {exp_pulse(), exp_idle(), exp_ov()}) begin
                n_bad++;
                $display("FAIL burst: cyc %0d got p=%b i=%b o=%b, want p=%b i=%b o=%b",
                         t, pulse_oh, idle_oh, ovrflw_oh, exp_pulse(), exp_idle(), exp_ov());
            end
            if (pulse_oh[0]) times.push_back(t - c0);
            if (pulse_oh[1] || ovrflw_oh != '0) ch1_seen++;
        end
        n_cmp++;
        if (times.size() != 5 || ch1_seen != 0) begin
            n_bad++;
            $display("FAIL burst_count: got %0d pulses stray=%0d, want 5 stray=0",
                     times.size(), ch1_seen);
        end
        for (int i = 0; i < times.size() && i < 5; i++) begin
            n_cmp++;
            if (times[i] != longint'(2 + i * (GAP + 1))) begin
                n_bad++;
                $display("FAIL burst_spacing: pulse %0d at %0d, want %0d", i, times[i], 2 + i * (GAP + 1));
            end
        end
    endtask

    task automatic test_saturation();
        int got, want;
        got  = 0;
        want = 0;
        for (int k = 0; k < 20; k++) begin
            step(2'b10, 2'b00);
            got  += int'(pulse_oh[1]);
            want += int'(m_out[1]);
        end
        n_cmp++;
        if (ovrflw_oh[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL sat_flag: got %b, want 1", ovrflw_oh[1]);
        end
        // Drop and clear in the same cycle: the set must win.
        step(2'b10, 2'b10);
        got  += int'(pulse_oh[1]);
        want += int'(m_out[1]);
        n_cmp++;
        if (ovrflw_oh[1] !== 1'b1 || m_ov[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL set_beats_clr: got %b, want 1", ovrflw_oh[1]);
        end
        step(2'b00, 2'b10);
        got  += int'(pulse_oh[1]);
        want += int'(m_out[1]);
        n_cmp++;
        if (ovrflw_oh[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL sat_clear: got %b, want 0", ovrflw_oh[1]);
        end
        for (int k = 0; k < 170; k++) begin
            step(2'b00, 2'b00);
            got  += int'(pulse_oh[1]);
            want += int'(m_out[1]);
            n_cmp++;
            if ({pulse_oh, idle_oh, ovrflw_oh} !== {exp_pulse(), exp_idle(), exp_ov()}) begin
                n_bad++;
                $display("FAIL sat_drain: cyc %0d got p=%b i=%b o=%b, want p=%b i=%b o=%b",
                         t, pulse_oh, idle_oh, ovrflw_oh, exp_pulse(), exp_idle(), exp_ov());
            end
        end
        n_cmp++;
        if (got != want || idle_oh[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL sat_count: got %0d pulses idle=%b, want %0d idle=1", got, idle_oh[1], want);
        end
    endtask

    task automatic test_async_reset();
        int residual;
        residual = 0;
        for (int k = 0; k < 14; k++) step((k < 6) ? 2'b11 : 2'b00, 2'b00);
        #2;
        rst_il = 1'b0;
        #1;
        n_cmp++;
        if ({pulse_oh, idle_oh, ovrflw_oh} !== {{N{1'b0}}, {N{1'b1}}, {N{1'b0}}}) begin
            n_bad++;
            $display("FAIL async_reset: got p=%b i=%b o=%b, want p=00 i=11 o=00",
                     pulse_oh, idle_oh, ovrflw_oh);
        end
        pulse_ih = '0;
        repeat (2) @(posedge clk_ir);
        #1;
        rst_il = 1'b1;
        model_reset();
        for (int k = 0; k < 40; k++) begin
            step(2'b00, 2'b00);
            if (pulse_oh != '0 || idle_oh != '1) residual++;
        end
        n_cmp++;
        if (residual != 0) begin
            n_bad++;
            $display("FAIL async_residual: got %0d busy cycles, want 0", residual);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] p, c;
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < N; i++) begin
                p[i] = ($urandom_range(0, 99) < 30);
                c[i] = ($urandom_range(0, 99) < 8);
            end
            step(p, c);
            n_cmp++;
            if ({pulse_oh, idle_oh, ovrflw_oh} !== {exp_pulse(), exp_idle(), exp_ov()}) begin
                n_bad++;
                $display("FAIL random: cyc %0d got p=%b i=%b o=%b, want p=%b i=%b o=%b",
                         t, pulse_oh, idle_oh, ovrflw_oh, exp_pulse(), exp_idle(), exp_ov());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_burst();
        test_saturation();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, want completion");
        $fatal(1, "timeout");
    end

endmodule
